// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state encoding, jump codes and redirect helper
package pipeline_hazard_controller_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] JUMP_NONE = 2'b00;

    function automatic logic is_redirect(input logic branch_taken, input logic [1:0] jump_sig);
        return branch_taken | (jump_sig != JUMP_NONE);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: ID/EX/MEM hazard inputs and pipeline control outputs
interface pipeline_hazard_controller_if;

    logic [4:0]  IDRs;
    logic [4:0]  IDRt;
    logic        IDUsesRt;
    logic        IDReadsHiLo;
    logic        MultStart;
    logic        EXMemRead;
    logic [4:0]  EXDestReg;
    logic        BranchTaken;
    logic [1:0]  JumpSig;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXFlush;
    logic        EXMEMFlush;
    logic        MultBusy;
    logic [15:0] StallCycles;

    modport master (
        output IDRs, IDRt, IDUsesRt, IDReadsHiLo, MultStart,
        output EXMemRead, EXDestReg, BranchTaken, JumpSig,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush,
        input  MultBusy, StallCycles
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, IDReadsHiLo, MultStart,
        input  EXMemRead, EXDestReg, BranchTaken, JumpSig,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush,
        output MultBusy, StallCycles
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX
module load_use_detect (
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_dest_reg,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_load_stall
);

    logic w_rs_hit;
    logic w_rt_hit;

    // $zero is never a real dependency, and Rt only matters when the instruction reads it
    always_comb begin
        w_rs_hit     = i_ex_dest_reg == i_id_rs;
        w_rt_hit     = i_id_uses_rt && (i_ex_dest_reg == i_id_rt);
        o_load_stall = i_ex_mem_read && (i_ex_dest_reg != 5'd0) && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush control for load-use, mult/div occupancy and redirects
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MULT_LATENCY = 4
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    pipeline_hazard_controller_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(MULT_LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_mult_cnt;
    logic [15:0] r_stall_cycles;
    logic        w_redirect;
    logic        w_load_stall;
    logic        w_mult_stall;
    logic        w_stall;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (bus.EXMemRead),
        .i_ex_dest_reg (bus.EXDestReg),
        .i_id_rs       (bus.IDRs),
        .i_id_rt       (bus.IDRt),
        .i_id_uses_rt  (bus.IDUsesRt),
        .o_load_stall  (w_load_stall)
    );

    // hazard classification: a redirect flushes everything younger, so it overrides any stall
    always_comb begin
        w_redirect   = is_redirect(bus.BranchTaken, bus.JumpSig);
        w_mult_stall = (r_state == MULT_WAIT) && (bus.IDReadsHiLo || bus.MultStart);
        w_stall      = (w_load_stall || w_mult_stall) && !w_redirect;
    end

    // pipeline controls; while in reset the front end is frozen and every stage flushed
    always_comb begin
        bus.PCWrite     = Rst_n && !w_stall;
        bus.IFIDWrite   = Rst_n && !w_stall;
        bus.IFIDFlush   = !Rst_n || w_redirect;
        bus.IDEXFlush   = !Rst_n || w_redirect || w_stall;
        bus.EXMEMFlush  = !Rst_n || w_redirect;
        bus.MultBusy    = r_state == MULT_WAIT;
        bus.StallCycles = r_stall_cycles;
    end

    // mult/div occupancy: a flushed or stalled issue never starts the unit, redirects never cut it short
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= RUN;
            r_mult_cnt <= 4'd0;
        end else if (r_state == RUN) begin
            if (bus.MultStart && !w_redirect && !w_load_stall) begin
                r_state    <= MULT_WAIT;
                r_mult_cnt <= CNT_LOAD;
            end
        end else if (r_mult_cnt == 4'd0) begin
            r_state <= RUN;
        end else begin
            r_mult_cnt <= r_mult_cnt - 4'd1;
        end
    end

    // saturating count of cycles in which the PC was held
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_stall_cycles <= 16'd0;
        else if (!bus.PCWrite && r_stall_cycles != 16'hFFFF)
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: random + directed stimulus against a cycle-level reference model
module tb_pipeline_hazard_controller;

    localparam int LAT = 4;

    typedef struct {
        logic        pcw;
        logic        ifidw;
        logic        ifidf;
        logic        idexf;
        logic        exmemf;
        logic        busy;
        logic [15:0] sc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    pipeline_hazard_controller_if bus();

    pipeline_hazard_controller #(.MULT_LATENCY(LAT)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   busy_left = 0;
    int   stalls = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cycle, name, act, exp);
        end
    endtask

    // monitor: outputs are valid every cycle, compare mid-cycle
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("PCWrite", int'(bus.PCWrite), int'(e.pcw));
            chk("IFIDWrite", int'(bus.IFIDWrite), int'(e.ifidw));
            chk("IFIDFlush", int'(bus.IFIDFlush), int'(e.ifidf));
            chk("IDEXFlush", int'(bus.IDEXFlush), int'(e.idexf));
            chk("EXMEMFlush", int'(bus.EXMEMFlush), int'(e.exmemf));
            chk("MultBusy", int'(bus.MultBusy), int'(e.busy));
            chk("StallCycles", int'(bus.StallCycles), int'(e.sc));
        end
    end

    task automatic clear_inputs();
        bus.IDRs = 5'd0; bus.IDRt = 5'd0; bus.IDUsesRt = 1'b0;
        bus.IDReadsHiLo = 1'b0; bus.MultStart = 1'b0;
        bus.EXMemRead = 1'b0; bus.EXDestReg = 5'd0;
        bus.BranchTaken = 1'b0; bus.JumpSig = 2'b00;
    endtask

    // model the current cycle from the rules, queue the expectation, then advance one clock
    task automatic tick();
        exp_t e;
        logic redirect, load, busy, mstall;
        if (!Rst_n) begin
            busy_left = 0;
            stalls = 0;
        end
        redirect = bus.BranchTaken || (bus.JumpSig != 2'b00);
        load = bus.EXMemRead && bus.EXDestReg != 0 &&
               (bus.EXDestReg == bus.IDRs || (bus.IDUsesRt && bus.EXDestReg == bus.IDRt));
        busy = busy_left > 0;
        mstall = busy && (bus.IDReadsHiLo || bus.MultStart);
        e.busy = busy;
        e.sc = 16'(stalls);
        if (!Rst_n) begin
            e.pcw = 0; e.ifidf = 1; e.idexf = 1; e.exmemf = 1;
        end else if (redirect) begin
            e.pcw = 1; e.ifidf = 1; e.idexf = 1; e.exmemf = 1;
        end else if (load || mstall) begin
            e.pcw = 0; e.ifidf = 0; e.idexf = 1; e.exmemf = 0;
        end else begin
            e.pcw = 1; e.ifidf = 0; e.idexf = 0; e.exmemf = 0;
        end
        e.ifidw = e.pcw;
        q.push_back(e);
        if (Rst_n) begin
            if (busy_left > 0) busy_left--;
            else if (bus.MultStart && !redirect && !load) busy_left = LAT;
            if (!e.pcw && stalls < 65535) stalls++;
        end
        @(posedge Clk);
        #1;
        cycle++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clear_inputs();
        @(posedge Clk);
        #1;
        ticks(3);
        Rst_n = 1'b1;
        ticks(2);
        // load-use on Rs, then $zero destination
        bus.EXMemRead = 1; bus.EXDestReg = 5'd8; bus.IDRs = 5'd8;
        tick();
        clear_inputs();
        tick();
        bus.EXMemRead = 1; bus.EXDestReg = 5'd0; bus.IDRs = 5'd0;
        tick();
        // Rt qualifier
        clear_inputs();
        bus.EXMemRead = 1; bus.EXDestReg = 5'd9; bus.IDRt = 5'd9; bus.IDRs = 5'd3;
        tick();
        bus.IDUsesRt = 1;
        tick();
        // multiply with a waiting mfhi
        clear_inputs();
        bus.MultStart = 1;
        tick();
        bus.MultStart = 0; bus.IDReadsHiLo = 1;
        ticks(6);
        // redirect beats load stall and mult issue
        clear_inputs();
        bus.MultStart = 1; bus.EXMemRead = 1; bus.EXDestReg = 5'd4; bus.IDRs = 5'd4;
        bus.BranchTaken = 1;
        tick();
        clear_inputs();
        bus.JumpSig = 2'b10; bus.MultStart = 1;
        tick();
        clear_inputs();
        bus.IDReadsHiLo = 1;
        ticks(2);
        // reset arriving while the multiplier counts down
        clear_inputs();
        bus.MultStart = 1;
        tick();
        bus.MultStart = 0; bus.IDReadsHiLo = 1;
        tick();
        Rst_n = 1'b0;
        ticks(2);
        Rst_n = 1'b1;
        ticks(2);
        // randomized traffic on a small register set so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            bus.IDRs = 5'($urandom_range(0, 3));
            bus.IDRt = 5'($urandom_range(0, 3));
            bus.IDUsesRt = 1'($urandom);
            bus.IDReadsHiLo = ($urandom_range(0, 3) == 0);
            bus.MultStart = ($urandom_range(0, 5) == 0);
            bus.EXMemRead = 1'($urandom);
            bus.EXDestReg = 5'($urandom_range(0, 3));
            bus.BranchTaken = ($urandom_range(0, 9) == 0);
            bus.JumpSig = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            Rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        Rst_n = 1'b1;
        clear_inputs();
        tick();
        // hold a load-use stall long enough to saturate the counter
        bus.EXMemRead = 1; bus.EXDestReg = 5'd7; bus.IDRs = 5'd7;
        ticks(65545);
        clear_inputs();
        ticks(2);
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        ticks(2);
        @(negedge Clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 4 (range 2..15), giving the multiply/divide unit occupancy in cycles.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports IDRs and IDRt, input, 5 each: source register numbers of the instruction in ID.
REQ-005 SHALL have port IDUsesRt, input, 1: the ID instruction reads Rt.
REQ-006 SHALL have port IDReadsHiLo, input, 1: the ID instruction is mfhi/mflo.
REQ-007 SHALL have port MultStart, input, 1: the ID instruction is mult/div (HiLoEnable nonzero).
REQ-008 SHALL have ports EXMemRead, input, 1, and EXDestReg, input, 5: ID/EX-stage load flag and destination.
REQ-009 SHALL have port BranchTaken, input, 1: branch resolved taken in MEM (PCSrc&Zero or BNE&!Zero).
REQ-010 SHALL have port JumpSig, input, 2: EX/MEM jump code; nonzero means redirect.
REQ-011 SHALL have ports PCWrite and IFIDWrite, output, 1 each: enables for PC and IF/ID.
REQ-012 SHALL have ports IFIDFlush, IDEXFlush and EXMEMFlush, output, 1 each; EXMEMFlush drives the EX/MEM FlushSignal.
REQ-013 SHALL have ports MultBusy, output, 1, and StallCycles, output, 16: performance counter.

Function
REQ-014 SHALL use a two-state FSM, RUN and MULT_WAIT, plus a 4-bit down-counter MultCnt.
REQ-015 SHALL assert Redirect = BranchTaken | (JumpSig != 0).
REQ-016 SHALL assert LoadStall = EXMemRead & EXDestReg!=0 & (EXDestReg==IDRs | (IDUsesRt & EXDestReg==IDRt)).
REQ-017 SHALL assert MultStall = (state==MULT_WAIT) & (IDReadsHiLo | MultStart).
REQ-018 SHALL make all outputs combinational from current state and inputs, with zero-cycle latency.
REQ-019 SHALL, on Redirect, drive IFIDFlush=IDEXFlush=EXMEMFlush=1 and PCWrite=IFIDWrite=1, ignoring all stalls.
REQ-020 SHALL, on MultStall or LoadStall with no Redirect, drive PCWrite=IFIDWrite=0, IDEXFlush=1, IFIDFlush=0 and EXMEMFlush=0.
REQ-021 SHALL otherwise drive PCWrite=IFIDWrite=1 with all flushes 0.
REQ-022 SHALL, in RUN with MultStart=1, no Redirect and no LoadStall, move to MULT_WAIT next cycle with MultCnt=MULT_LATENCY-1.
REQ-023 SHALL ignore MultStart when Redirect=1, because the issuing instruction is being flushed.
REQ-024 SHALL, in MULT_WAIT, decrement MultCnt each cycle and return to RUN in the cycle after MultCnt==1→0 (MultCnt==0 ⇒ RUN next).
REQ-025 SHALL keep Redirect from altering MULT_WAIT or MultCnt, since the multiply belongs to an older instruction.
REQ-026 SHALL drive MultBusy=1 exactly while state==MULT_WAIT.
REQ-027 SHALL increment StallCycles each cycle PCWrite==0 with Rst_n high, and saturate at 0xFFFF without wrap.

Reset
REQ-028 SHALL, while Rst_n is low, hold state=RUN, MultCnt=0 and StallCycles=0.
REQ-029 SHALL, while Rst_n is low, drive PCWrite=IFIDWrite=0, all three flushes=1 and MultBusy=0.
REQ-030 SHALL, when reset is asserted mid-multiply, abandon MULT_WAIT immediately (asynchronously).
REQ-031 SHALL, after reset deassertion, apply REQ-019..REQ-021 from the first Clk edge.

Structure
REQ-032 SHALL place the state encoding (RUN=0, MULT_WAIT=1) and the JumpSig none-code (2'b00) in the shared pipeline package.
REQ-033 SHALL implement the hazard detection as a single sub-module, load_use_detect, and keep the FSM and counters in the top level.

Verification
REQ-034 SHALL cover load-use: EXMemRead=1, EXDestReg=8, IDRs=8 → for one cycle PCWrite=0, IDEXFlush=1 and StallCycles +1; with EXDestReg=0 → no stall.
REQ-035 SHALL cover the Rt qualifier: EXDestReg=9, IDRt=9, IDUsesRt=0 → no stall; IDUsesRt=1 → stall.
REQ-036 SHALL cover multiply: MultStart pulse with MULT_LATENCY=4 → MultBusy high for 4 cycles; IDReadsHiLo=1 throughout → PCWrite=0 for those 4 cycles, then 1.
REQ-037 SHALL cover priority: Redirect coincident with LoadStall and MultStart in RUN → all flushes 1, PCWrite=1, state stays RUN.
REQ-038 SHALL cover reset mid-operation: Rst_n low during MULT_WAIT with MultCnt=2 → MultBusy=0 immediately, flushes=1, StallCycles=0.
REQ-039 SHALL cover saturation: force ≥65536 stall cycles → StallCycles holds 0xFFFF.
